// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions, timer state encoding and byte-lane merge helper.
// Imported by mmio_timer and mmio_timer_prescaler.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;
  localparam logic [4:0] OFF_CAPTURE  = 5'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQ   = 2;
  localparam int STAT_MATCH = 0;
  localparam int STAT_CAP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: counts 0..prescale while running and emits a one-cycle tick on the wrap cycle.
// Tick is combinational from the counter (same-cycle); clear forces the counter back to 0.
module mmio_timer_prescaler
  import mmio_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = run && (pcnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped compare timer (one-shot / auto-reload, level irq); zero-latency reads, writes on the edge, no stalls.
// Optional COUNT capture input and CAPTURE register are compiled in with MMIO_TIMER_CAPTURE_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_rd_req_i,
  input  logic [31:0] mem_rd_addr_i,
  output logic [31:0] mem_rd_data_o,
  input  logic        mem_wd_req_i,
  input  logic [3:0]  mem_wd_sel_i,
  input  logic [31:0] mem_wd_addr_i,
  input  logic [31:0] mem_wd_data_i,
  output logic        irq_o
`ifdef MMIO_TIMER_CAPTURE_EN
  ,
  input  logic        capture_i
`endif
);

  import mmio_timer_pkg::*;

  state_t                state;
  logic [2:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match;
  logic                  cap_flag;
  logic [31:0]           capture_q;

  logic       rd_hit;
  logic       wr_hit;
  logic [4:0] rd_off;
  logic [4:0] wr_off;
  logic       ctrl_wr;
  logic       prescale_wr;
  logic       count_wr;
  logic       compare_wr;
  logic       status_wr;
  logic       match_w1c;
  logic       run;
  logic       tick;
  logic       hit;
  logic       one_shot_done;
  logic       unused_addr_lsbs;

  // Window is 32 bytes, so only addr[31:5] selects the block and addr[1:0] is ignored.
  assign rd_hit = mem_rd_req_i && (mem_rd_addr_i[31:5] == BASE_ADDR[31:5]);
  assign wr_hit = mem_wd_req_i && (mem_wd_addr_i[31:5] == BASE_ADDR[31:5]);
  assign rd_off = {mem_rd_addr_i[4:2], 2'b00};
  assign wr_off = {mem_wd_addr_i[4:2], 2'b00};
  assign unused_addr_lsbs = ^{mem_rd_addr_i[1:0], mem_wd_addr_i[1:0]};

  assign ctrl_wr     = wr_hit && (wr_off == OFF_CTRL) && mem_wd_sel_i[0];
  assign prescale_wr = wr_hit && (wr_off == OFF_PRESCALE) && (|mem_wd_sel_i);
  assign count_wr    = wr_hit && (wr_off == OFF_COUNT) && (|mem_wd_sel_i);
  assign compare_wr  = wr_hit && (wr_off == OFF_COMPARE) && (|mem_wd_sel_i);
  assign status_wr   = wr_hit && (wr_off == OFF_STATUS) && mem_wd_sel_i[0];
  assign match_w1c   = status_wr && mem_wd_data_i[STAT_MATCH];

  assign run           = (state == ST_RUN);
  assign hit           = tick && (count == compare);
  assign one_shot_done = hit && !ctrl[CTRL_AUTO];

  mmio_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .clear    (prescale_wr),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_EXPIRED: begin
          if (ctrl_wr && mem_wd_data_i[CTRL_EN]) state <= ST_RUN;
        end
        ST_RUN: begin
          // A software CTRL write in the expiry cycle decides the next state.
          if (ctrl_wr) begin
            if (!mem_wd_data_i[CTRL_EN]) state <= ST_IDLE;
          end else if (one_shot_done) begin
            state <= ST_EXPIRED;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= '0;
      match    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= mem_wd_data_i[2:0];
      end else if (one_shot_done) begin
        ctrl[CTRL_EN] <= 1'b0;
      end

      if (prescale_wr) begin
        prescale <= PRESCALE_W'(apply_sel(32'(prescale), mem_wd_data_i, mem_wd_sel_i));
      end

      if (compare_wr) begin
        compare <= apply_sel(compare, mem_wd_data_i, mem_wd_sel_i);
      end

      if (count_wr) begin
        count <= apply_sel(count, mem_wd_data_i, mem_wd_sel_i);
      end else if (tick) begin
        if (!hit) begin
          count <= count + 32'd1;
        end else if (ctrl[CTRL_AUTO]) begin
          count <= '0;
        end
      end

      if (hit) begin
        match <= 1'b1;
      end else if (match_w1c) begin
        match <= 1'b0;
      end
    end
  end

`ifdef MMIO_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;
  logic       cap_rise;
  logic       cap_w1c;

  // Two synchroniser flops plus one history flop for rising-edge detection.
  assign cap_rise = cap_sync[1] && !cap_sync[2];
  assign cap_w1c  = status_wr && mem_wd_data_i[STAT_CAP];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_sync  <= '0;
      capture_q <= '0;
      cap_flag  <= 1'b0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_i};
      if (cap_rise) begin
        capture_q <= count;
        cap_flag  <= 1'b1;
      end else if (cap_w1c) begin
        cap_flag <= 1'b0;
      end
    end
  end
`else
  assign capture_q = '0;
  assign cap_flag  = 1'b0;
`endif

  assign irq_o = ctrl[CTRL_IRQ] && (match || cap_flag);

  always_comb begin
    mem_rd_data_o = '0;
    if (rd_hit) begin
      case (rd_off)
        OFF_CTRL:     mem_rd_data_o = {29'd0, ctrl};
        OFF_PRESCALE: mem_rd_data_o = 32'(prescale);
        OFF_COUNT:    mem_rd_data_o = count;
        OFF_COMPARE:  mem_rd_data_o = compare;
        OFF_STATUS:   mem_rd_data_o = {30'd0, cap_flag, match};
        OFF_CAPTURE:  mem_rd_data_o = capture_q;
        default:      mem_rd_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, one-shot, auto-reload, byte lanes, priorities, mid-count reset.
// Capture scenario is compiled when MMIO_TIMER_CAPTURE_EN is defined.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_PRESCALE = 32'h04;
  localparam logic [31:0] A_COUNT    = 32'h08;
  localparam logic [31:0] A_COMPARE  = 32'h0C;
  localparam logic [31:0] A_STATUS   = 32'h10;
  localparam logic [31:0] A_CAPTURE  = 32'h14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        wd_req = 1'b0;
  logic [3:0]  wd_sel = '0;
  logic [31:0] wd_addr = '0;
  logic [31:0] wd_data = '0;
  logic        irq;
`ifdef MMIO_TIMER_CAPTURE_EN
  logic        capture = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mmio_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_rd_req_i  (rd_req),
    .mem_rd_addr_i (rd_addr),
    .mem_rd_data_o (rd_data),
    .mem_wd_req_i  (wd_req),
    .mem_wd_sel_i  (wd_sel),
    .mem_wd_addr_i (wd_addr),
    .mem_wd_data_i (wd_data),
    .irq_o         (irq)
`ifdef MMIO_TIMER_CAPTURE_EN
    ,
    .capture_i     (capture)
`endif
  );

  // Called at a falling edge; the write lands on the next rising edge and the task returns one falling edge later.
  task automatic wr_raw(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    wd_req  = 1'b1;
    wd_addr = addr;
    wd_data = data;
    wd_sel  = sel;
    @(negedge clk);
    wd_req  = 1'b0;
    wd_sel  = '0;
    wd_data = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    wr_raw(BASE + off, data, 4'hF);
  endtask

  task automatic rd_raw(input logic [31:0] addr, output logic [31:0] data);
    rd_req  = 1'b1;
    rd_addr = addr;
    #1;
    data    = rd_data;
    rd_req  = 1'b0;
    rd_addr = '0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] data);
    rd_raw(BASE + off, data);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd(32'(4 * i), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", i, d); end
    end
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    logic        exp_irq;
    wr(A_PRESCALE, 32'd0);
    wr(A_COMPARE, 32'd5);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) @(negedge clk);
      exp_irq = (i == 6) ? 1'b1 : 1'b0;
      total++; if (irq !== exp_irq) begin bad++; $display("FAIL oneshot_irq cyc=%0d got=%b exp=%b", i, irq, exp_irq); end
    end
    rd(A_COUNT, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL oneshot_count got=%h exp=5", d); end
    rd(A_CTRL, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=4", d); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status got=%h exp=1", d); end
    repeat (3) @(negedge clk);
    rd(A_COUNT, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL oneshot_hold got=%h exp=5", d); end
    wr(A_STATUS, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_w1c_irq got=%b exp=0", irq); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_w1c_status got=%h exp=0", d); end
  endtask

  task automatic test_auto_reload;
    logic [31:0] d;
    logic [31:0] exp_cnt;
    logic        exp_match;
    wr(A_CTRL, 32'h0);
    wr(A_COUNT, 32'd0);
    wr(A_PRESCALE, 32'd3);
    wr(A_COMPARE, 32'd2);
    wr(A_CTRL, 32'h3);
    // Ticks land on edges 4,8,12,...; COUNT walks 0,1,2 and reloads with a match on edges 12 and 24.
    for (int i = 1; i <= 24; i++) begin
      if (i == 14) wr(A_STATUS, 32'h1);
      else @(negedge clk);
      exp_cnt   = 32'((i / 4) % 3);
      exp_match = ((i >= 12 && i < 14) || i == 24) ? 1'b1 : 1'b0;
      rd(A_COUNT, d);
      total++; if (d !== exp_cnt) begin bad++; $display("FAIL auto_count cyc=%0d got=%h exp=%h", i, d, exp_cnt); end
      rd(A_STATUS, d);
      total++; if (d !== {31'd0, exp_match}) begin bad++; $display("FAIL auto_match cyc=%0d got=%h exp=%b", i, d, exp_match); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_irq cyc=%0d got=%b exp=0", i, irq); end
    end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_byte_lanes;
    logic [31:0] d;
    wr(A_COMPARE, 32'd0);
    wr_raw(BASE + A_COMPARE, 32'hAABB_CCDD, 4'b0101);
    rd(A_COMPARE, d);
    total++; if (d !== 32'h00BB_00DD) begin bad++; $display("FAIL lanes_0101 got=%h exp=00bb00dd", d); end
    wr_raw(BASE + 32'h2C, 32'hFFFF_FFFF, 4'hF);
    rd(A_COMPARE, d);
    total++; if (d !== 32'h00BB_00DD) begin bad++; $display("FAIL lanes_outwin_wr got=%h exp=00bb00dd", d); end
    wr_raw(BASE + A_COMPARE, 32'h1111_1111, 4'b0000);
    rd(A_COMPARE, d);
    total++; if (d !== 32'h00BB_00DD) begin bad++; $display("FAIL lanes_nosel got=%h exp=00bb00dd", d); end
    wr_raw(BASE + A_COMPARE + 32'h2, 32'h7700_0000, 4'b1000);
    rd(A_COMPARE, d);
    total++; if (d !== 32'h77BB_00DD) begin bad++; $display("FAIL lanes_lsb_ignored got=%h exp=77bb00dd", d); end
    rd_raw(BASE + 32'h2C, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL lanes_outwin_rd got=%h exp=0", d); end
    rd(A_CAPTURE + 32'h4, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL lanes_unmapped got=%h exp=0", d); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] d;
    wr(A_PRESCALE, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_COMPARE, 32'd3);
    wr(A_CTRL, 32'h5);
    repeat (3) @(negedge clk);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL setclr_match got=%h exp=1", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL setclr_irq got=%b exp=1", irq); end
    wr(A_STATUS, 32'h0);
    rd(A_STATUS, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL setclr_w0 got=%h exp=1", d); end
    wr(A_STATUS, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL setclr_irq_fall got=%b exp=0", irq); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL setclr_cleared got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    wr(A_COMPARE, 32'hFFFF_FFFF);
    wr(A_PRESCALE, 32'd0);
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'd100);
    rd(A_COUNT, d);
    total++; if (d !== 32'd100) begin bad++; $display("FAIL b2b_sw_wins got=%h exp=64", d); end
    @(negedge clk);
    rd(A_COUNT, d);
    total++; if (d !== 32'd101) begin bad++; $display("FAIL b2b_inc got=%h exp=65", d); end
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, d);
    total++; if (d !== 32'd102) begin bad++; $display("FAIL b2b_stop got=%h exp=66", d); end
    @(negedge clk);
    rd(A_COUNT, d);
    total++; if (d !== 32'd102) begin bad++; $display("FAIL b2b_idle_frozen got=%h exp=66", d); end
    @(negedge clk);
    wd_req  = 1'b1;
    wd_addr = BASE + A_COUNT;
    wd_data = 32'h55;
    wd_sel  = 4'hF;
    rd(A_COUNT, d);
    total++; if (d !== 32'd102) begin bad++; $display("FAIL b2b_rd_prewrite got=%h exp=66", d); end
    @(negedge clk);
    wd_req = 1'b0;
    wd_sel = '0;
    rd(A_COUNT, d);
    total++; if (d !== 32'h55) begin bad++; $display("FAIL b2b_rd_postwrite got=%h exp=55", d); end
  endtask

  task automatic test_midcount_reset;
    logic [31:0] d;
    wr(A_PRESCALE, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_COMPARE, 32'd10);
    wr(A_CTRL, 32'h7);
    repeat (3) @(negedge clk);
    rd(A_COUNT, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL rst_precount got=%h exp=3", d); end
    rd_raw(BASE + 32'h40, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_outwin got=%h exp=0", d); end
    reset_n = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd(32'(4 * i), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_reg%0d got=%h exp=0", i, d); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq_after got=%b exp=0", irq); end
  endtask

`ifdef MMIO_TIMER_CAPTURE_EN
  task automatic test_capture;
    logic [31:0] d;
    wr(A_COUNT, 32'd7);
    wr(A_CTRL, 32'h4);
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    repeat (3) @(negedge clk);
    rd(A_CAPTURE, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL cap_value got=%h exp=7", d); end
    rd(A_STATUS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL cap_status got=%h exp=2", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL cap_irq got=%b exp=1", irq); end
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cap_w1c got=%h exp=0", d); end
  endtask
`else
  task automatic test_capture;
    logic [31:0] d;
    wr(A_CTRL, 32'h4);
    wr(A_STATUS, 32'h2);
    rd(A_CAPTURE, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL nocap_reg got=%h exp=0", d); end
    rd(A_STATUS, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL nocap_status got=%h exp=0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL nocap_irq got=%b exp=0", irq); end
    wr(A_CTRL, 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_byte_lanes();
    test_same_cycle();
    test_back_to_back();
    test_midcount_reset();
    test_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
